timer_counter: RTL

Memory-mapped timer/counter peripheral that responds to the CPU-side bus bridge on the M stage. It implements the word-level register window (CTRL, PRESET, COUNT) that the bridge reads combinationally and writes with pre-merged 32-bit words. It runs a one-shot or auto-reload down-count state machine and raises a maskable interrupt request to the CP0/interrupt logic. One instance is placed per timer window (TC0, TC1).

---
 rtl/timer_counter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-count timer with maskable interrupt.
//
// Register window (word offset = Addr[1:0]):
//   0 CTRL   [0] Enable, [2:1] Mode (1 = auto-reload, else one-shot),
//            [3] IM (interrupt mask), [31:4] read as 0
//   1 PRESET reload value
//   2 COUNT  current count (read-only)
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-low reset
//   Addr   word address; only Addr[1:0] is decoded
//   WE     write strobe, already qualified by window select
//   Din    merged 32-bit write word
//   Dout   combinational read of the addressed register
//   IRQ    interrupt request = irq_flag & CTRL.IM
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nx;
    logic        irq_flag;
    logic        irq_nx;
    logic        en_clr;

    logic        enable;
    logic        auto_reload;
    logic        irq_mask;
    logic [1:0]  offset;
    logic        wr_ctrl;
    logic        wr_preset;

    // Window selection is done by the bridge; upper address bits are unused.
    logic        unused_addr;
    assign unused_addr = ^Addr[29:2];

    assign offset      = Addr[1:0];
    assign enable      = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign irq_mask    = ctrl[3];
    assign wr_ctrl     = WE && (offset == OFF_CTRL);
    assign wr_preset   = WE && (offset == OFF_PRESET);

    // State register, counter and interrupt flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            irq_flag <= irq_nx;
        end
    end

    // CTRL: a CPU write in the same cycle as the one-shot auto-clear
    // of Enable takes priority over the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl <= 4'd0;
        end else if (wr_ctrl) begin
            ctrl <= Din[3:0];
        end else if (en_clr) begin
            ctrl[0] <= 1'b0;
        end
    end

    // PRESET is only sampled into COUNT in LOAD, so a write while
    // counting does not disturb the running count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= Din;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        count_nx = count;
        irq_nx   = irq_flag;
        en_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                count_nx = preset;
                irq_nx   = 1'b0;
                state_nx = CNT;
            end
            CNT: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (count > 32'd1) begin
                    count_nx = count - 32'd1;
                end else begin
                    // COUNT<=1 covers PRESET=0, which then acts as 1.
                    count_nx = 32'd0;
                    irq_nx   = 1'b1;
                    state_nx = INT;
                end
            end
            INT: begin
                if (auto_reload) begin
                    // Enable stays set, so IDLE goes straight to LOAD.
                    irq_nx   = 1'b0;
                    state_nx = IDLE;
                end else begin
                    // One-shot keeps irq_flag until the next LOAD.
                    en_clr   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Read mux.
    always_comb begin
        Dout = 32'd0;
        unique case (offset)
            OFF_CTRL:   Dout = {28'd0, ctrl};
            OFF_PRESET: Dout = preset;
            OFF_COUNT:  Dout = count;
            OFF_RSVD:   Dout = 32'd0;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag & irq_mask;

endmodule
